// File: rtl/uart_32_bit_rx.sv
// uart_32_bit_rx: oversampled 8N1 receiver assembling four little-endian bytes into one 32-bit word
module uart_32_bit_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int GAP_BITS   = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        baud_tick,
  input  logic        rx,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        frame_err,
  output logic        gap_err,
  output logic        busy
);
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int GAP_LIM = GAP_BITS * OVERSAMPLE;
  localparam int GW      = $clog2(GAP_LIM + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t      state_q, state_d;
  logic        meta_q, sync_q;
  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [23:0] asm_q, asm_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d, ferr_q, ferr_d, gerr_q, gerr_d;
  logic        tick_end, half_end;
  assign tick_end = tick_q == TW'(OVERSAMPLE - 1);
  assign half_end = tick_q == TW'(OVERSAMPLE / 2 - 1);
  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    gap_d      = gap_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    ferr_d     = 1'b0;
    gerr_d     = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!sync_q) begin
            state_d = START;
            tick_d  = '0;
            gap_d   = '0;
          end else if (byte_cnt_q != 2'd0) begin
            gap_d = gap_q + GW'(1);
            if (gap_q == GW'(GAP_LIM - 1)) begin
              gerr_d     = 1'b1;
              byte_cnt_d = 2'd0;
              gap_d      = '0;
            end
          end
        end
        START: begin
          tick_d = half_end ? '0 : tick_q + TW'(1);
          if (half_end) state_d = sync_q ? IDLE : DATA;
        end
        DATA: begin
          tick_d = tick_end ? '0 : tick_q + TW'(1);
          if (tick_end) begin
            shift_d = {sync_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = STOP;
          end
        end
        default: begin
          tick_d = tick_end ? '0 : tick_q + TW'(1);
          if (tick_end) begin
            state_d = IDLE;
            if (!sync_q) begin
              ferr_d     = 1'b1;
              byte_cnt_d = 2'd0;
            end else begin
              // bytes enter from the top so the first byte ends up in bits 7:0
              asm_d      = {shift_q, asm_q[23:8]};
              byte_cnt_d = byte_cnt_q + 2'd1;
              if (byte_cnt_q == 2'd3) begin
                data_d  = {shift_q, asm_q};
                valid_d = 1'b1;
              end
            end
          end
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q     <= 1'b1;
      sync_q     <= 1'b1;
      state_q    <= IDLE;
      tick_q     <= '0;
      gap_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      ferr_q     <= 1'b0;
      gerr_q     <= 1'b0;
    end else begin
      meta_q     <= rx;
      sync_q     <= meta_q;
      state_q    <= state_d;
      tick_q     <= tick_d;
      gap_q      <= gap_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      ferr_q     <= ferr_d;
      gerr_q     <= gerr_d;
    end
  end
  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign gap_err   = gerr_q;
  assign busy      = (state_q != IDLE) || (byte_cnt_q != 2'd0);
endmodule

// File: tb/tb_uart_32_bit_rx.sv
// tb_uart_32_bit_rx: directed frames with a scoreboard of expected output pulses
module tb_uart_32_bit_rx;
  logic        clk = 1'b0, rst = 1'b0, baud_tick = 1'b0, rx = 1'b1;
  logic [31:0] rx_data;
  logic        rx_valid, frame_err, gap_err, busy;
  int          div = 0;
  int          total = 0, bad = 0;
  typedef struct {logic [1:0] kind; logic [31:0] data;} ev_t;
  ev_t q[$];
  localparam logic [1:0] K_VALID = 2'd0, K_FRAME = 2'd1, K_GAP = 2'd2;
  localparam int BIT = 64;

  uart_32_bit_rx #(.OVERSAMPLE(16), .GAP_BITS(20)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err),
    .gap_err(gap_err), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    div       <= (div == 3) ? 0 : div + 1;
    baud_tick <= (div == 3);
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (rx_valid || frame_err || gap_err) begin
      ev_t e;
      logic [1:0] k;
      k = rx_valid ? K_VALID : frame_err ? K_FRAME : K_GAP;
      total++;
      if (int'(rx_valid) + int'(frame_err) + int'(gap_err) > 1) begin
        bad++;
        $display("FAIL exclusive: valid=%0b frame=%0b gap=%0b, required at most one", rx_valid, frame_err, gap_err);
      end else if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: kind=%0d data=%h, required no pulse", k, rx_data);
      end else begin
        e = q.pop_front();
        if (e.kind !== k || (k == K_VALID && e.data !== rx_data)) begin
          bad++;
          $display("FAIL pulse: kind=%0d data=%h, required kind=%0d data=%h", k, rx_data, e.kind, e.data);
        end
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [1:0] k, input logic [31:0] d);
    ev_t e;
    e.kind = k;
    e.data = d;
    q.push_back(e);
  endtask

  task automatic drain(input string name);
    wclk(200);
    check(name, 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    wclk(BIT);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wclk(BIT);
    end
    rx = stop;
    wclk(BIT);
    rx = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) send_byte(t[8*i +: 8], 1'b1);
  endtask

  initial begin
    wclk(3);
    check("reset_rx_data", rx_data, 32'h0);
    check("reset_pulses", {29'd0, rx_valid, frame_err, gap_err}, 32'h0);
    check("reset_busy", {31'd0, busy}, 32'h0);
    rst = 1'b1;
    wclk(5);

    rx = 1'b0;
    wclk(16);
    check("glitch_busy_seen", {31'd0, busy}, 32'h1);
    rx = 1'b1;
    wclk(2 * BIT);
    check("glitch_busy_clear", {31'd0, busy}, 32'h0);
    drain("glitch_no_pulse");

    expect_ev(K_FRAME, 32'h0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b0);
    wclk(2 * BIT);
    check("frame_rx_data_held", rx_data, 32'h0);
    check("frame_busy_clear", {31'd0, busy}, 32'h0);
    expect_ev(K_VALID, 32'hDEADBEEF);
    send_word(32'hDEADBEEF);
    drain("frame_recover_pulses");
    check("frame_recover_data", rx_data, 32'hDEADBEEF);

    expect_ev(K_VALID, 32'h12345678);
    send_word(32'h12345678);
    drain("basic_pulses");
    check("basic_data", rx_data, 32'h12345678);

    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    expect_ev(K_GAP, 32'h0);
    wclk(21 * BIT);
    check("gap_busy_clear", {31'd0, busy}, 32'h0);
    drain("gap_pulses");
    check("gap_rx_data_held", rx_data, 32'h12345678);
    expect_ev(K_VALID, 32'hCAFEF00D);
    send_word(32'hCAFEF00D);
    drain("gap_recover_pulses");
    check("gap_recover_data", rx_data, 32'hCAFEF00D);

    expect_ev(K_VALID, 32'hA1B2C3D4);
    expect_ev(K_VALID, 32'h87654321);
    send_word(32'hA1B2C3D4);
    send_word(32'h87654321);
    drain("b2b_pulses");
    check("b2b_data", rx_data, 32'h87654321);

    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    rx = 1'b0;
    wclk(BIT);
    rx = 1'b1;
    wclk(BIT);
    rx = 1'b0;
    wclk(20);
    check("midframe_busy", {31'd0, busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    check("async_rx_data", rx_data, 32'h0);
    check("async_pulses", {29'd0, rx_valid, frame_err, gap_err}, 32'h0);
    check("async_busy", {31'd0, busy}, 32'h0);
    rx = 1'b1;
    wclk(10);
    rst = 1'b1;
    wclk(10);
    expect_ev(K_VALID, 32'h04030201);
    send_word(32'h04030201);
    drain("post_reset_pulses");
    check("post_reset_data", rx_data, 32'h04030201);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_32_bit_rx.md
UART_32_BIT_RX -- requirements
Module: uart_32_bit_rx

Interface
REQ-001 SHALL provide parameter OVERSAMPLE, default 16: baud_tick pulses per serial bit; even value, 8..64.
REQ-002 SHALL provide parameter GAP_BITS, default 20: maximum idle bit-times allowed between bytes of one word.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port baud_tick  input  1  one-clk pulse at OVERSAMPLE x bit rate, from uart_32_bit_baud_rate.
REQ-006 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port rx_data  output  32  last complete received word.
REQ-008 SHALL have port rx_valid  output  1  one-clk pulse when rx_data updates.
REQ-009 SHALL have port frame_err  output  1  one-clk pulse on bad stop bit.
REQ-010 SHALL have port gap_err  output  1  one-clk pulse on inter-byte timeout.
REQ-011 SHALL have port busy  output  1  high whenever state is not IDLE or a partial word is held.

Function
REQ-012 SHALL pass rx through a 2-flop synchronizer (reset value 1); all decisions use the synchronized value.
REQ-013 SHALL advance the tick counter, bit sampling and timeouts only on clk edges where baud_tick=1.
REQ-014 SHALL implement states IDLE, START, DATA, STOP.
REQ-015 IDLE -> START on a baud_tick with synchronized rx=0; tick counter cleared.
REQ-016 START: after OVERSAMPLE/2 ticks, sample rx; 0 -> DATA with counter cleared; 1 -> IDLE (false start, no error, partial word kept).
REQ-017 DATA: sample every OVERSAMPLE ticks, 8 bits, LSB first, into byte shift register; after 8th sample -> STOP.
REQ-018 STOP: after OVERSAMPLE ticks, sample rx; 1 -> store byte at rx_data lane byte_cnt (byte 0 = bits 7:0, little-endian), byte_cnt+1, -> IDLE.
REQ-019 Stop sample 0 SHALL pulse frame_err, discard the partial word (byte_cnt=0), leave rx_data unchanged, -> IDLE.
REQ-020 When byte_cnt wraps 3 -> 0 on a good stop bit, rx_data SHALL update with all 4 bytes and rx_valid SHALL pulse on the same clk.
REQ-021 rx_data SHALL NOT change except at REQ-020; partial bytes are held in an internal 24-bit assembly register.
REQ-022 In IDLE with byte_cnt!=0, a gap counter SHALL count baud_ticks; reaching GAP_BITS*OVERSAMPLE SHALL pulse gap_err, clear byte_cnt, leave rx_data unchanged.
REQ-023 The gap counter SHALL clear on every IDLE->START transition.
REQ-024 rx_valid, frame_err and gap_err SHALL be mutually exclusive and at most one clk wide.
REQ-025 A start edge arriving on the clk following a STOP->IDLE transition SHALL be accepted (back-to-back frames, no dead time).
REQ-026 Counter widths SHALL cover GAP_BITS*OVERSAMPLE without overflow; no wrap within a valid count.

Reset
REQ-027 rst=0 SHALL asynchronously force: state IDLE, rx_data=0, rx_valid=0, frame_err=0, gap_err=0, busy=0, byte_cnt=0, all counters 0, synchronizer flops 1.
REQ-028 Reset asserted mid-frame SHALL abandon the frame; after release, no output pulse until a new full word is received.
REQ-029 Release of rst SHALL be usable on any clk edge; first start detection no earlier than 2 clks after release (synchronizer latency).

Verification
REQ-030 Bench: baud_tick every 4 clks, OVERSAMPLE=16; send bytes 0x78,0x56,0x34,0x12 with valid stop bits -> rx_valid one pulse, rx_data=0x12345678, no error pulses.
REQ-031 Bench: 0.25-bit-time low glitch on rx in IDLE -> no state beyond START, busy returns 0, no pulses.
REQ-032 Bench: 2nd byte sent with stop bit 0 -> frame_err one pulse, rx_data stays 0; next 4 good bytes 0xEF,0xBE,0xAD,0xDE -> rx_data=0xDEADBEEF.
REQ-033 Bench: send 2 bytes then idle 21 bit-times -> gap_err one pulse, busy=0; next 4 bytes form a new word from lane 0.
REQ-034 Bench: assert rst low during DATA of byte 3 -> all outputs 0 immediately (async); after release, 4 new bytes 0x01,0x02,0x03,0x04 -> rx_data=0x04030201.
REQ-035 Bench: two words sent back-to-back, no idle between stop and start bits -> two rx_valid pulses, correct values each.
